// File: rtl/mojo_serial_pkg.sv
// Shared constants and state type for the mojo serial blocks.
package mojo_serial_pkg;

  localparam int BYTE_W                 = 8;
  localparam int DEFAULT_BLOCK_BYTES    = 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } block_state_t;

endpackage

// File: rtl/mojo_serial_timeout.sv
// Idle-cycle timer: counts enabled cycles, expires on the TIMEOUT_CYCLES-th one.
module mojo_serial_timeout
  import mojo_serial_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  // Combinational so the owner can act in the same cycle as the last idle one.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mojo_serial_block_in.sv
// Assembles UART bytes into MSB-first blocks of BLOCK_BYTES bytes.
// Optional inter-byte timeout enabled by macro MOJO_SERIAL_BLOCK_IN_TIMEOUT_EN.
module mojo_serial_block_in
  import mojo_serial_pkg::*;
#(
  parameter int BLOCK_BYTES    = DEFAULT_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          new_rx_data,
  output logic [BLOCK_BYTES*BYTE_W-1:0] rx_block,
  output logic                          new_rx_block,
  output logic                          rx_block_busy,
  output logic                          rx_timeout
);

  localparam int W     = BLOCK_BYTES * BYTE_W;
  localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;

  if (BLOCK_BYTES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("mojo_serial_block_in: BLOCK_BYTES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  block_state_t state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [W-1:0]     assembly, assembly_n;
  logic             load;
  logic             timeout_n;
  logic             expired;

`ifdef MOJO_SERIAL_BLOCK_IN_TIMEOUT_EN
  mojo_serial_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable ((state == FILL) && !new_rx_data),
    .clear  (new_rx_data || (state != FILL)),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  // A strobe always wins over timer expiry, so a late byte is never lost.
  always_comb begin
    state_n    = state;
    count_n    = count;
    assembly_n = assembly;
    load       = 1'b0;
    timeout_n  = 1'b0;
    if (new_rx_data) begin
      assembly_n = (assembly << BYTE_W) | W'(rx_data);
      if (count == CNT_W'(BLOCK_BYTES - 1)) begin
        load    = 1'b1;
        count_n = '0;
        state_n = IDLE;
      end else begin
        count_n = count + CNT_W'(1);
        state_n = FILL;
      end
    end else if (expired) begin
      assembly_n = '0;
      count_n    = '0;
      state_n    = IDLE;
      timeout_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      assembly     <= '0;
      rx_block     <= '0;
      new_rx_block <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      assembly     <= assembly_n;
      new_rx_block <= load;
      if (load) begin
        rx_block <= assembly_n;
      end
    end
  end

`ifdef MOJO_SERIAL_BLOCK_IN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= timeout_n;
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

  assign rx_block_busy = (state == FILL);

endmodule
